ysyx_22051468_mul_div_unit: RTL

- Iterative RV64M multiply/divide unit in the execute stage; consumes the decoded is_mul/is_div/is_rem/is_U/is_W class and operands from the decode-to-exec register.
- Produces hold_pipeline, the stall request that freezes the upstream pipeline registers while an M-extension operation runs.
- Shift-add multiplier and restoring divider share one datapath; one result per accepted operation.

---
 rtl/ysyx_22051468_mul_div_unit_pkg.sv | 30 +++
 rtl/ysyx_22051468_Dff.sv | 24 ++
 rtl/ysyx_22051468_mul_div_core.sv | 113 +++++++++++
 rtl/ysyx_22051468_mul_div_unit.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22051468_mul_div_unit_pkg.sv
// Shared constants for the RV64M multiply/divide unit: funct3 operation
// codes, FSM state encoding and small operand-class helpers.
package ysyx_22051468_mul_div_unit_pkg;

    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // rs1 is treated as a signed value for these operations
    function automatic logic op_signed_a(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    // rs2 is treated as a signed value for these operations (MULHSU excluded)
    function automatic logic op_signed_b(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/ysyx_22051468_Dff.sv
// Generic register with synchronous active-high reset and load enable.
module ysyx_22051468_Dff #(
    parameter int                 WIDTH     = 1,
    parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Register with reset value and load enable
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/ysyx_22051468_mul_div_core.sv
// Iteration datapath shared by the shift-add multiplier and the restoring
// divider, plus the final sign fixup and result selection.
//   acc : product accumulator (multiply) / partial remainder (divide)
//   opb : multiplicand shifted left each step / divisor
//   shf : multiplier shifted right / dividend shifted out, quotient shifted in
// result_o is derived from the next-state values so the top can capture the
// finished result on the same edge that performs the last iteration.
module ysyx_22051468_mul_div_core
    import ysyx_22051468_mul_div_unit_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             load_div_i,
    input  logic             load_w_i,
    input  logic             step_i,
    input  logic [2:0]       op_i,
    input  logic             is_w_i,
    input  logic             neg_p_i,
    input  logic             neg_r_i,
    input  logic [WIDTH-1:0] mag_a_i,
    input  logic [WIDTH-1:0] mag_b_i,
    output logic [WIDTH-1:0] result_o
);

    localparam int H = WIDTH / 2;

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0]   shf_q, shf_d;
    logic [2*WIDTH-1:0] sum_s;
    logic [WIDTH:0]     rem_shift_s;
    logic [WIDTH:0]     diff_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s, quo_f_s, rem_s, rem_f_s, raw_s;

    // Next-state: operand load, one shift-add step or one restoring step
    always_comb begin
        acc_d       = acc_q;
        opb_d       = opb_q;
        shf_d       = shf_q;
        sum_s       = acc_q + opb_q;
        rem_shift_s = {acc_q[WIDTH-1:0], shf_q[WIDTH-1]};
        diff_s      = rem_shift_s - {1'b0, opb_q[WIDTH-1:0]};
        if (load_i) begin
            acc_d = {(2*WIDTH){1'b0}};
            if (load_div_i) begin
                opb_d = {{WIDTH{1'b0}}, mag_b_i};
                // W divides pre-align the dividend so its MSB is always shf[WIDTH-1]
                shf_d = load_w_i ? {mag_a_i[H-1:0], {H{1'b0}}} : mag_a_i;
            end else begin
                opb_d = {{WIDTH{1'b0}}, mag_a_i};
                shf_d = mag_b_i;
            end
        end else if (step_i) begin
            if (op_i[2]) begin
                if (!diff_s[WIDTH]) begin
                    acc_d = {{WIDTH{1'b0}}, diff_s[WIDTH-1:0]};
                    shf_d = {shf_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {{WIDTH{1'b0}}, rem_shift_s[WIDTH-1:0]};
                    shf_d = {shf_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                if (shf_q[0]) begin
                    acc_d = sum_s;
                end else begin
                    acc_d = acc_q;
                end
                opb_d = {opb_q[2*WIDTH-2:0], 1'b0};
                shf_d = {1'b0, shf_q[WIDTH-1:1]};
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // Sign fixup and result selection from the post-step values
    always_comb begin
        prod_s  = neg_p_i ? (~acc_d + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc_d;
        quo_s   = is_w_i ? {{H{1'b0}}, shf_d[H-1:0]} : shf_d;
        quo_f_s = neg_p_i ? (~quo_s + {{(WIDTH-1){1'b0}}, 1'b1}) : quo_s;
        rem_s   = acc_d[WIDTH-1:0];
        rem_f_s = neg_r_i ? (~rem_s + {{(WIDTH-1){1'b0}}, 1'b1}) : rem_s;
        case (op_i)
            MD_MUL:                      raw_s = prod_s[WIDTH-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: raw_s = prod_s[2*WIDTH-1:WIDTH];
            MD_DIV, MD_DIVU:             raw_s = quo_f_s;
            default:                     raw_s = rem_f_s;
        endcase
        if (is_w_i) begin
            result_o = {{H{raw_s[H-1]}}, raw_s[H-1:0]};
        end else begin
            result_o = raw_s;
        end
    end

    // Iteration registers
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= {(2*WIDTH){1'b0}};
            opb_q <= {(2*WIDTH){1'b0}};
            shf_q <= {WIDTH{1'b0}};
        end else begin
            acc_q <= acc_d;
            opb_q <= opb_d;
            shf_q <= shf_d;
        end
    end

endmodule

// File: rtl/ysyx_22051468_mul_div_unit.sv
// Iterative RV64M multiply/divide unit. Accepts one operation in IDLE,
// iterates N cycles in BUSY (N = WIDTH or WIDTH/2 for W forms), and presents
// the result with a one-cycle valid pulse in DONE. Divide-by-zero and signed
// overflow are resolved at accept time and go straight to DONE.
module ysyx_22051468_mul_div_unit
    import ysyx_22051468_mul_div_unit_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic             is_W_i,
    input  logic [WIDTH-1:0] rs1_data_i,
    input  logic [WIDTH-1:0] rs2_data_i,
    input  logic             flush_i,
    output logic             hold_pipeline_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int H  = WIDTH / 2;
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] N_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] N_HALF = CW'(H);

    md_state_e        state_q, state_d;
    logic [1:0]       state_raw_q;
    logic [CW-1:0]    counter_q, counter_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [2:0]       op_q, op_d;
    logic             is_w_q, is_w_d;
    logic             neg_p_q, neg_p_d;
    logic             neg_r_q, neg_r_d;

    logic             sgn_a_s, sgn_b_s, neg_a_s, neg_b_s;
    logic [WIDTH-1:0] src_a_s, src_b_s, mag_a_s, mag_b_s;
    logic [WIDTH-1:0] min_s, dividend_s, special_res_s, core_res_s;
    logic             div_zero_s, div_ovf_s, special_s;
    logic             load_s, step_s, hold_s;

    // Operand width/sign conditioning and divide special-case detection
    always_comb begin
        sgn_a_s = op_signed_a(op_i);
        sgn_b_s = op_signed_b(op_i);
        if (is_W_i) begin
            src_a_s = sgn_a_s ? {{H{rs1_data_i[H-1]}}, rs1_data_i[H-1:0]}
                              : {{H{1'b0}}, rs1_data_i[H-1:0]};
            src_b_s = sgn_b_s ? {{H{rs2_data_i[H-1]}}, rs2_data_i[H-1:0]}
                              : {{H{1'b0}}, rs2_data_i[H-1:0]};
            min_s      = {{(H+1){1'b1}}, {(H-1){1'b0}}};
            dividend_s = {{H{rs1_data_i[H-1]}}, rs1_data_i[H-1:0]};
        end else begin
            src_a_s    = rs1_data_i;
            src_b_s    = rs2_data_i;
            min_s      = {1'b1, {(WIDTH-1){1'b0}}};
            dividend_s = rs1_data_i;
        end
        neg_a_s    = sgn_a_s & src_a_s[WIDTH-1];
        neg_b_s    = sgn_b_s & src_b_s[WIDTH-1];
        mag_a_s    = neg_a_s ? (~src_a_s + {{(WIDTH-1){1'b0}}, 1'b1}) : src_a_s;
        mag_b_s    = neg_b_s ? (~src_b_s + {{(WIDTH-1){1'b0}}, 1'b1}) : src_b_s;
        div_zero_s = op_i[2] & (src_b_s == {WIDTH{1'b0}});
        div_ovf_s  = op_i[2] & ~op_i[0] & (src_a_s == min_s) & (src_b_s == {WIDTH{1'b1}});
        special_s  = div_zero_s | div_ovf_s;
        if (div_zero_s) begin
            special_res_s = op_i[1] ? dividend_s : {WIDTH{1'b1}};
        end else begin
            special_res_s = op_i[1] ? {WIDTH{1'b0}} : src_a_s;
        end
    end

    // FSM next state, counter, captured operation and stall request
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        result_d  = result_q;
        op_d      = op_q;
        is_w_d    = is_w_q;
        neg_p_d   = neg_p_q;
        neg_r_d   = neg_r_q;
        load_s    = 1'b0;
        step_s    = 1'b0;
        hold_s    = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (start_i && !flush_i) begin
                    hold_s  = 1'b1;
                    load_s  = 1'b1;
                    op_d    = op_i;
                    is_w_d  = is_W_i;
                    neg_p_d = neg_a_s ^ neg_b_s;
                    neg_r_d = neg_a_s;
                    if (special_s) begin
                        state_d   = MD_DONE;
                        counter_d = {CW{1'b0}};
                        result_d  = special_res_s;
                    end else begin
                        state_d   = MD_BUSY;
                        counter_d = is_W_i ? N_HALF : N_FULL;
                    end
                end else begin
                    state_d = MD_IDLE;
                end
            end
            MD_BUSY: begin
                hold_s    = 1'b1;
                step_s    = 1'b1;
                counter_d = counter_q - CW'(1);
                if (counter_q == CW'(1)) begin
                    state_d  = MD_DONE;
                    result_d = core_res_s;
                end else begin
                    state_d = MD_BUSY;
                end
            end
            MD_DONE: begin
                state_d = MD_IDLE;
            end
            default: begin
                state_d   = MD_IDLE;
                counter_d = {CW{1'b0}};
            end
        endcase
        // A redirect kills whatever is in flight and leaves the result untouched
        if (flush_i) begin
            state_d   = MD_IDLE;
            counter_d = {CW{1'b0}};
            result_d  = result_q;
            hold_s    = 1'b0;
        end else begin
            hold_s = hold_s;
        end
    end

    ysyx_22051468_Dff #(.WIDTH(2), .RESET_VAL(2'd0)) u_state_reg (
        .clk(clk), .rst(rst), .en(1'b1), .d(state_d), .q(state_raw_q)
    );

    ysyx_22051468_Dff #(.WIDTH(CW), .RESET_VAL({CW{1'b0}})) u_counter_reg (
        .clk(clk), .rst(rst), .en(1'b1), .d(counter_d), .q(counter_q)
    );

    ysyx_22051468_Dff #(.WIDTH(WIDTH), .RESET_VAL({WIDTH{1'b0}})) u_result_reg (
        .clk(clk), .rst(rst), .en(1'b1), .d(result_d), .q(result_q)
    );

    assign state_q = md_state_e'(state_raw_q);

    // Captured operation class and sign-fixup flags
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= 3'd0;
            is_w_q  <= 1'b0;
            neg_p_q <= 1'b0;
            neg_r_q <= 1'b0;
        end else begin
            op_q    <= op_d;
            is_w_q  <= is_w_d;
            neg_p_q <= neg_p_d;
            neg_r_q <= neg_r_d;
        end
    end

    ysyx_22051468_mul_div_core #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load_s),
        .load_div_i(op_i[2]),
        .load_w_i  (is_W_i),
        .step_i    (step_s),
        .op_i      (op_q),
        .is_w_i    (is_w_q),
        .neg_p_i   (neg_p_q),
        .neg_r_i   (neg_r_q),
        .mag_a_i   (mag_a_s),
        .mag_b_i   (mag_b_s),
        .result_o  (core_res_s)
    );

    assign hold_pipeline_o = hold_s;
    assign valid_o         = (state_q == MD_DONE) & ~flush_i;
    assign result_o        = result_q;

endmodule
